dpram_fifo_ctrl: RTL

//  - Initiator/controller for a dpram instance, turning it into a streaming FIFO.
//  - Port A is the write port: it is written from a valid/ready input stream.
//  - Port B is the read port: it is read into a valid/ready output stream.
//  - The dpram is instantiated outside this block, wired to the ram_* ports.
//  - Hides the dpram's 1-cycle registered read latency behind a 2-entry output buffer.
//  - Sustains 1 word/cycle in and out.

---
 rtl/dpram_fifo_ctrl_if.sv | 38 +++
 rtl/dpram_fifo_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl_if.sv
// Stream and dpram-side signals of the dpram FIFO controller.
// The controller connects through "slave"; the environment (source, sink, dpram) uses "master".
interface dpram_fifo_ctrl_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DWIDTH-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DWIDTH-1:0] rd_data;

    logic [AWIDTH+1:0] level;

    logic [AWIDTH-1:0] ram_address_a;
    logic              ram_wren_a;
    logic [DWIDTH-1:0] ram_data_a;
    logic [AWIDTH-1:0] ram_address_b;
    logic              ram_wren_b;
    logic [DWIDTH-1:0] ram_data_b;
    logic [DWIDTH-1:0] ram_out_b;

    modport slave (
        input  wr_valid, wr_data, rd_ready, ram_out_b,
        output wr_ready, rd_valid, rd_data, level,
        output ram_address_a, ram_wren_a, ram_data_a,
        output ram_address_b, ram_wren_b, ram_data_b
    );

    modport master (
        output wr_valid, wr_data, rd_ready, ram_out_b,
        input  wr_ready, rd_valid, rd_data, level,
        input  ram_address_a, ram_wren_a, ram_data_a,
        input  ram_address_b, ram_wren_b, ram_data_b
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller around an external dpram: port A is written from the input
// stream, port B is read ahead into a 2-entry output buffer that hides the RAM read latency.
module dpram_fifo_ctrl #(
    parameter int AWIDTH    = 10,
    parameter int NUM_WORDS = 1024,
    parameter int DWIDTH    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    dpram_fifo_ctrl_if.slave    bus
);
    localparam int PW = AWIDTH + 1;
    localparam int LW = AWIDTH + 2;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              r_inflight;
    logic [1:0]        r_ob_cnt;
    logic [DWIDTH-1:0] r_ob [2];
    logic [LW-1:0]     r_level;

    logic [PW-1:0]     w_used;
    logic              w_wr_ready;
    logic              w_accept;
    logic              w_rd_valid;
    logic              w_pop;
    logic [2:0]        w_committed;
    logic              w_issue;

    // w_used counts words in RAM not yet issued; the extra pointer bit separates full from empty.
    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_wr_ready  = resetn & (w_used != PW'(NUM_WORDS));
    assign w_accept    = bus.wr_valid & w_wr_ready;
    assign w_rd_valid  = (r_ob_cnt != 2'd0);
    assign w_pop       = w_rd_valid & bus.rd_ready;

    // Buffer slots still spoken for after this edge; a new read is issued only if one stays free.
    assign w_committed = 3'(r_ob_cnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue     = (w_used != '0) & (w_committed < 3'd2);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_ob_cnt   <= 2'd0;
            r_level    <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_issue)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_inflight <= w_issue;
            r_ob_cnt   <= w_committed[1:0];
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: buffer payload has no reset; r_ob_cnt alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        case ({r_inflight, w_pop})
            2'b01: r_ob[0] <= r_ob[1];
            2'b10: r_ob[r_ob_cnt[0]] <= bus.ram_out_b;
            2'b11: begin
                if (r_ob_cnt == 2'd1) begin
                    r_ob[0] <= bus.ram_out_b;
                end else begin
                    r_ob[0] <= r_ob[1];
                    r_ob[1] <= bus.ram_out_b;
                end
            end
            default: ;
        endcase
    end

    assign bus.wr_ready      = w_wr_ready;
    assign bus.rd_valid      = w_rd_valid;
    assign bus.rd_data       = r_ob[0];
    assign bus.level         = r_level;
    assign bus.ram_address_a = r_wr_ptr[AWIDTH-1:0];
    assign bus.ram_wren_a    = w_accept;
    assign bus.ram_data_a    = bus.wr_data;
    assign bus.ram_address_b = r_rd_ptr[AWIDTH-1:0];
    assign bus.ram_wren_b    = 1'b0;
    assign bus.ram_data_b    = '0;

    a_buffer_bound: assert property (@(posedge clk) disable iff (!resetn)
        (3'(r_ob_cnt) + 3'(r_inflight)) <= 3'd2);

    a_level_bound: assert property (@(posedge clk) disable iff (!resetn)
        r_level <= LW'(NUM_WORDS + 2));

    a_stall_stable: assert property (@(posedge clk) disable iff (!resetn)
        (w_rd_valid && !bus.rd_ready) |=> (w_rd_valid && $stable(bus.rd_data)));
endmodule
